// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and helpers for the multiport register file.
// Optional same-cycle write bypass is enabled by the RF_BYPASS_EN macro.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

  // Bit offset of port i in a flattened bus of w-bit fields.
  function automatic int rf_off(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits and their registered popcount.
// Issue sets a bit, writeback clears it; a set beats a clear on one address.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      wa0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      wa1,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_nxt;
  logic [ADDR_W:0] cnt_nxt;

  // Next busy vector: clears first, then the issue set overrides them.
  always_comb begin
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[RF_ZERO_REG] = 1'b0;
    cnt_nxt = '0;
    for (int j = 0; j < NREG; j++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[j]);
  end

  // Busy flops and the count that always equals their popcount.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: NUM_RD async read ports, two write ports, busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  logic w0_ok;
  logic w1_ok;
  logic is_ok;

  assign w0_ok = we0 && (wa0 != ZERO);
  assign w1_ok = we1 && (wa1 != ZERO);
  assign is_ok = iss_en && (iss_addr != ZERO);

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we0      (w0_ok),
    .wa0      (wa0),
    .we1      (w1_ok),
    .wa1      (wa1),
    .iss_en   (is_ok),
    .iss_addr (iss_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Storage; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        regs[k] <= '0;
    end else begin
      if (w0_ok) regs[wa0] <= wd0;
      if (w1_ok) regs[wa1] <= wd1;
    end
  end

  // Read muxes and per-port busy lookup.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[rf_off(i, ADDR_W) +: ADDR_W];
      rd[rf_off(i, DATA_W) +: DATA_W] =
        (a == ZERO) ? '0 : regs[a];
      rd_busy[i] = busy[a];
`ifdef RF_BYPASS_EN
      if (w1_ok && wa1 == a)
        rd[rf_off(i, DATA_W) +: DATA_W] = wd1;
      else if (w0_ok && wa0 == a)
        rd[rf_off(i, DATA_W) +: DATA_W] = wd0;
      if (((w0_ok && wa0 == a) || (w1_ok && wa1 == a))
          && !(is_ok && iss_addr == a))
        rd_busy[i] = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed plan plus random traffic vs a behavioural model.
// Expectations follow RF_BYPASS_EN when the bench is built with it.
module tb_rf_multiport;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_busy;
  logic              we0, we1, iss_en;
  logic [AW-1:0]     wa0, wa1, iss_addr;
  logic [DW-1:0]     wd0, wd1;
  logic [AW:0]       busy_cnt;

  rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] m_reg  [NREG];
  bit            m_busy [NREG];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pop();
    int n = 0;
    for (int k = 0; k < NREG; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (((we0 && int'(wa0) == a) || (we1 && int'(wa1) == a))
        && !(iss_en && int'(iss_addr) == a))
      return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0;
    wa0 = '0; wa1 = '0; iss_addr = '0;
    wd0 = '0; wd1 = '0;
  endtask

  task automatic set_ra(input int a0, input int a1);
    ra = {AW'(a1), AW'(a0)};
  endtask

  task automatic check_reads(input string tag);
    #1;
    for (int p = 0; p < NR; p++) begin
      int a;
      a = int'(ra[p*AW +: AW]);
      check({tag, "_rd"}, 64'(rd[p*DW +: DW]), 64'(exp_rd(a)));
      check({tag, "_busy"}, 64'(rd_busy[p]), 64'(exp_busy(a)));
    end
  endtask

  // Model update for the inputs present at the coming edge.
  task automatic tick(input string tag);
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        m_reg[k] = '0;
        m_busy[k] = 0;
      end
    end else begin
      if (we0 && wa0 != 0) begin
        m_reg[wa0] = wd0; m_busy[wa0] = 0;
      end
      if (we1 && wa1 != 0) begin
        m_reg[wa1] = wd1; m_busy[wa1] = 0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
    @(posedge clk);
    #1;
    check({tag, "_cnt"}, 64'(busy_cnt), 64'(pop()));
  endtask

  initial begin
    rst = 1; idle(); set_ra(0, 0);
    tick("rst");
    rst = 0;

    set_ra(1, 9);
    check_reads("after_rst");
    check("after_rst_rd0", 64'(rd[DW-1:0]), 64'h0);
    check("after_rst_rd1", 64'(rd[2*DW-1:DW]), 64'h0);
    check("after_rst_cnt0", 64'(busy_cnt), 64'h0);

    for (int i = 1; i <= 9; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = DW'(i);
      tick("fill");
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      set_ra(2*k, 2*k+1);
      check_reads("pair");
      check("pair_lo", 64'(rd[DW-1:0]), 64'(2*k));
      check("pair_hi", 64'(rd[2*DW-1:DW]), 64'(2*k+1));
    end

    we0 = 1; wa0 = '0; wd0 = 32'hDEAD;
    tick("w_zero");
    idle(); set_ra(0, 0);
    check_reads("zero_reg");
    check("zero_reg_const", 64'(rd[DW-1:0]), 64'h0);

    we0 = 1; wa0 = 5; wd0 = 32'h11;
    we1 = 1; wa1 = 5; wd1 = 32'h22;
    tick("conflict");
    idle(); set_ra(5, 0);
    check_reads("conflict");
    check("conflict_r5", 64'(rd[DW-1:0]), 64'h22);

    iss_en = 1; iss_addr = 3; tick("iss3");
    iss_addr = 4; tick("iss4");
    idle(); set_ra(3, 4);
    check("iss_cnt2", 64'(busy_cnt), 64'd2);
    check_reads("iss");
    check("iss_busy3", 64'(rd_busy[0]), 64'h1);

    we0 = 1; wa0 = 3; wd0 = 32'h33; iss_en = 1; iss_addr = 3;
    set_ra(3, 4);
    check_reads("set_clr");
    tick("set_clr");
    idle();
    check_reads("set_clr_post");
    check("set_clr_cnt", 64'(busy_cnt), 64'd2);
    check("set_clr_r3", 64'(rd[DW-1:0]), 64'h33);
    check("set_clr_busy", 64'(rd_busy[0]), 64'h1);

    we0 = 1; wa0 = 3; wd0 = 32'h3;
    we1 = 1; wa1 = 4; wd1 = 32'h4;
    tick("wb34");
    idle();
    check("wb34_cnt", 64'(busy_cnt), 64'd0);

    for (int i = 1; i <= 3; i++) begin
      iss_en = 1; iss_addr = AW'(i + 10); tick("iss_multi");
    end
    idle();
    check("mid_cnt3", 64'(busy_cnt), 64'd3);
    rst = 1; we0 = 1; wa0 = 2; wd0 = 32'h55;
    tick("mid_rst");
    rst = 0; idle();
    check("mid_rst_cnt", 64'(busy_cnt), 64'd0);
    for (int k = 0; k < NREG/2; k++) begin
      set_ra(2*k, 2*k+1);
      #1;
      check("mid_rst_rd", 64'(rd), 64'h0);
      check("mid_rst_busy", 64'(rd_busy), 64'h0);
    end

    we0 = 1; wa0 = 7; wd0 = 32'h77;
    tick("pre_byp");
    idle();
    we1 = 1; wa1 = 7; wd1 = 32'hABCD; set_ra(7, 0);
    check_reads("byp");
`ifdef RF_BYPASS_EN
    check("byp_same", 64'(rd[DW-1:0]), 64'hABCD);
`else
    check("byp_old", 64'(rd[DW-1:0]), 64'h77);
`endif
    tick("byp");
    idle();
    check_reads("byp_after");
    check("byp_after_r7", 64'(rd[DW-1:0]), 64'hABCD);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      we0 = 1'($urandom); we1 = 1'($urandom);
      iss_en = 1'($urandom);
      wa0 = AW'($urandom_range(0, (n % 3 == 0) ? 31 : 7));
      wa1 = AW'($urandom_range(0, (n % 5 == 0) ? 31 : 7));
      iss_addr = AW'($urandom_range(0, (n % 4 == 0) ? 31 : 7));
      wd0 = $urandom; wd1 = $urandom;
      set_ra($urandom_range(0, 7), $urandom_range(0, 31));
      check_reads("rnd");
      tick("rnd");
    end
    rst = 0; idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
